// File: rtl/adder16_pkg.sv
// Shared definitions for the adder16 result capture stage.
//   DATA_W/FLAG_W/ENTRY_W : widths of the adder sum, its status flags and a stored entry
//   FLG_*                 : bit positions of each status flag inside the packed flag field
//   entry_t               : one stored FIFO word, {flags, z}
//   pack_flags()          : builds the flag field from the individual adder flags
package adder16_pkg;

   localparam int DATA_W  = 16;
   localparam int FLAG_W  = 5;
   localparam int ENTRY_W = DATA_W + FLAG_W;

   localparam int FLG_CARRY  = 0;
   localparam int FLG_SIGN   = 1;
   localparam int FLG_PARITY = 2;
   localparam int FLG_ZERO   = 3;
   localparam int FLG_OVF    = 4;

   typedef struct packed {
      logic [FLAG_W-1:0] flags;
      logic [DATA_W-1:0] z;
   } entry_t;

   function automatic logic [FLAG_W-1:0] pack_flags(
      input logic ovf,
      input logic zero,
      input logic parity,
      input logic sign,
      input logic carry
   );
      logic [FLAG_W-1:0] f;
      f             = '0;
      f[FLG_OVF]    = ovf;
      f[FLG_ZERO]   = zero;
      f[FLG_PARITY] = parity;
      f[FLG_SIGN]   = sign;
      f[FLG_CARRY]  = carry;
      return f;
   endfunction

endpackage

// File: rtl/adder16_result_fifo_if.sv
// Handshake/data bundle between the adder, the result FIFO and the next stage.
//   master : the environment side (drives adder result, out_ready, clr_sticky)
//   slave  : the FIFO side (drives in_ready, head word, occupancy and overflow status)
// Parameters must match the FIFO instance attached to the slave modport.
interface adder16_result_fifo_if #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
);
   import adder16_pkg::*;

   localparam int CNT_BITS = $clog2(DEPTH) + 1;

   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   z;
   logic                carry;
   logic                sign;
   logic                parity;
   logic                zero;
   logic                overflow;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_W-1:0]   out_z;
   logic [FLAG_W-1:0]   out_flags;
   logic [CNT_BITS-1:0] count;
   logic                full;
   logic                empty;
   logic                sticky_ovf;
   logic                clr_sticky;
   logic [CNT_W-1:0]    ovf_cnt;

   modport master (
      output in_valid, z, carry, sign, parity, zero, overflow, out_ready, clr_sticky,
      input  in_ready, out_valid, out_z, out_flags, count, full, empty, sticky_ovf, ovf_cnt
   );

   modport slave (
      input  in_valid, z, carry, sign, parity, zero, overflow, out_ready, clr_sticky,
      output in_ready, out_valid, out_z, out_flags, count, full, empty, sticky_ovf, ovf_cnt
   );

endinterface

// File: rtl/adder16_fifo_mem.sv
// Storage array for the result FIFO: DEPTH entries of {flags, z}.
//   clk       : write clock
//   i_wr_en   : write i_wr_data into i_wr_addr at the rising edge
//   i_wr_addr : write slot
//   i_wr_data : entry to store
//   i_rd_addr : read slot (combinational read)
//   o_rd_data : entry at i_rd_addr
// Storage is not reset; the owner tracks which slots hold live data.
module adder16_fifo_mem
   import adder16_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     i_wr_en,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  entry_t                   i_wr_data,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output entry_t                   o_rd_data
);

   logic [ENTRY_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = entry_t'(r_mem[i_rd_addr]);

endmodule

// File: rtl/adder16_result_fifo.sv
// Result capture FIFO sitting behind the 16-bit adder.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; flushes the FIFO and the overflow status
//   bus : slave side of adder16_result_fifo_if
//         in_valid/in_ready, z + flags   : upstream push handshake
//         out_valid/out_ready, out_z/out_flags : show-ahead head word, zero when empty
//         count/full/empty               : occupancy
//         sticky_ovf/ovf_cnt/clr_sticky  : overflow status, saturating counter, clear
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module adder16_result_fifo
   import adder16_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   adder16_result_fifo_if.slave bus
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] OVF_ONE  = CNT_W'(1);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_sticky_ovf;
   logic [CNT_W-1:0] r_ovf_cnt;

   logic             w_full;
   logic             w_empty;
   logic             w_in_ready;
   logic             w_push;
   logic             w_pop;
   logic             w_ovf_event;
   entry_t           w_wr_entry;
   entry_t           w_rd_entry;

   assign w_full      = (r_count == CNT_FULL);
   assign w_empty     = (r_count == '0);
   // in_ready is forced low during reset so no push can land in the flush cycle.
   assign w_in_ready  = !rst && !w_full;
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = !rst && !w_empty && bus.out_ready;
   assign w_ovf_event = w_push && bus.overflow;

   always_comb begin
      w_wr_entry       = '0;
      w_wr_entry.flags = pack_flags(bus.overflow, bus.zero, bus.parity, bus.sign, bus.carry);
      w_wr_entry.z     = bus.z;
   end

   adder16_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_wr_entry),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_entry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // A new overflow event in the same cycle as a clear takes precedence:
   // the clear empties the counter and this event is counted as the first.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sticky_ovf <= 1'b0;
         r_ovf_cnt    <= '0;
      end else if (w_ovf_event) begin
         r_sticky_ovf <= 1'b1;
         if (bus.clr_sticky) begin
            r_ovf_cnt <= OVF_ONE;
         end else if (r_ovf_cnt != '1) begin
            r_ovf_cnt <= r_ovf_cnt + OVF_ONE;
         end
      end else if (bus.clr_sticky) begin
         r_sticky_ovf <= 1'b0;
         r_ovf_cnt    <= '0;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = !w_empty;
   assign bus.out_z      = w_empty ? '0 : w_rd_entry.z;
   assign bus.out_flags  = w_empty ? '0 : w_rd_entry.flags;
   assign bus.count      = r_count;
   assign bus.full       = w_full;
   assign bus.empty      = w_empty;
   assign bus.sticky_ovf = r_sticky_ovf;
   assign bus.ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_adder16_result_fifo.sv
// Bench for adder16_result_fifo: two instances (CNT_W=8 and CNT_W=2) share
// the same stimulus; a queue-based model predicts contents and overflow status.
module tb_adder16_result_fifo;

   localparam int DEPTH = 4;
   localparam int MAX_A = 255;
   localparam int MAX_B = 3;

   logic        clk;
   logic        t_rst;
   logic        t_in_valid;
   logic [15:0] t_z;
   logic        t_carry;
   logic        t_sign;
   logic        t_parity;
   logic        t_zero;
   logic        t_ovf;
   logic        t_out_ready;
   logic        t_clr;

   int n_checks;
   int n_errors;

   logic [20:0] q[$];
   bit          m_sticky;
   int          m_cnt_a;
   int          m_cnt_b;

   adder16_result_fifo_if #(.DEPTH(DEPTH), .CNT_W(8)) bus_a ();
   adder16_result_fifo_if #(.DEPTH(DEPTH), .CNT_W(2)) bus_b ();

   assign bus_a.in_valid   = t_in_valid;
   assign bus_a.z          = t_z;
   assign bus_a.carry      = t_carry;
   assign bus_a.sign       = t_sign;
   assign bus_a.parity     = t_parity;
   assign bus_a.zero       = t_zero;
   assign bus_a.overflow   = t_ovf;
   assign bus_a.out_ready  = t_out_ready;
   assign bus_a.clr_sticky = t_clr;

   assign bus_b.in_valid   = t_in_valid;
   assign bus_b.z          = t_z;
   assign bus_b.carry      = t_carry;
   assign bus_b.sign       = t_sign;
   assign bus_b.parity     = t_parity;
   assign bus_b.zero       = t_zero;
   assign bus_b.overflow   = t_ovf;
   assign bus_b.out_ready  = t_out_ready;
   assign bus_b.clr_sticky = t_clr;

   adder16_result_fifo #(.DEPTH(DEPTH), .CNT_W(8)) dut_a (
      .clk (clk),
      .rst (t_rst),
      .bus (bus_a)
   );

   adder16_result_fifo #(.DEPTH(DEPTH), .CNT_W(2)) dut_b (
      .clk (clk),
      .rst (t_rst),
      .bus (bus_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic check_state();
      logic [20:0] head;
      head = (q.size() != 0) ? q[0] : 21'h0;
      chk("count",       bus_a.count,      q.size());
      chk("empty",       bus_a.empty,      q.size() == 0);
      chk("full",        bus_a.full,       q.size() == DEPTH);
      chk("out_valid",   bus_a.out_valid,  q.size() != 0);
      chk("out_z",       bus_a.out_z,      head[15:0]);
      chk("out_flags",   bus_a.out_flags,  head[20:16]);
      chk("sticky",      bus_a.sticky_ovf, m_sticky);
      chk("ovf_cnt",     bus_a.ovf_cnt,    m_cnt_a);
      chk("count_b",     bus_b.count,      q.size());
      chk("out_z_b",     bus_b.out_z,      head[15:0]);
      chk("sticky_b",    bus_b.sticky_ovf, m_sticky);
      chk("ovf_cnt_b",   bus_b.ovf_cnt,    m_cnt_b);
   endtask

   // One clock: apply inputs, check the combinational handshake, clock it,
   // advance the model, check the registered state.
   task automatic cyc(input logic v, input logic [15:0] zz, input logic [4:0] fl,
                      input logic ordy, input logic clr, input logic r);
      bit push;
      bit pop;
      t_in_valid  = v;
      t_z         = zz;
      {t_ovf, t_zero, t_parity, t_sign, t_carry} = fl;
      t_out_ready = ordy;
      t_clr       = clr;
      t_rst       = r;
      #1;
      chk("in_ready",   bus_a.in_ready, !r && (q.size() < DEPTH));
      chk("in_ready_b", bus_b.in_ready, !r && (q.size() < DEPTH));
      push = v && !r && (q.size() < DEPTH);
      pop  = !r && (q.size() != 0) && ordy;
      @(posedge clk);
      #1;
      if (r) begin
         q.delete();
         m_sticky = 1'b0;
         m_cnt_a  = 0;
         m_cnt_b  = 0;
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back({fl, zz});
         if (push && fl[4]) begin
            m_sticky = 1'b1;
            if (clr) begin
               m_cnt_a = 1;
               m_cnt_b = 1;
            end else begin
               m_cnt_a = (m_cnt_a == MAX_A) ? MAX_A : m_cnt_a + 1;
               m_cnt_b = (m_cnt_b == MAX_B) ? MAX_B : m_cnt_b + 1;
            end
         end else if (clr) begin
            m_sticky = 1'b0;
            m_cnt_a  = 0;
            m_cnt_b  = 0;
         end
      end
      check_state();
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      m_sticky    = 1'b0;
      m_cnt_a     = 0;
      m_cnt_b     = 0;
      t_rst       = 1'b1;
      t_in_valid  = 1'b1;
      t_z         = 16'h5555;
      {t_ovf, t_zero, t_parity, t_sign, t_carry} = 5'b10000;
      t_out_ready = 1'b0;
      t_clr       = 1'b0;

      // Reset, with a pending overflow word that must not be taken.
      @(posedge clk);
      #1;
      chk("in_ready_in_rst", bus_a.in_ready, 0);
      @(posedge clk);
      #1;
      check_state();

      // Idle after reset.
      cyc(0, 16'h0, 5'b00000, 0, 0, 0);
      chk("idle_out_z", bus_a.out_z, 16'h0000);

      // Single word: F0F0 + 0F0F.
      cyc(1, 16'hFFFF, 5'b00010, 0, 0, 0);
      chk("single_valid", bus_a.out_valid, 1);
      chk("single_z",     bus_a.out_z,     16'hFFFF);
      chk("single_flags", bus_a.out_flags, 5'b00010);
      cyc(0, 16'h0, 5'b00000, 1, 0, 0);
      chk("single_empty", bus_a.empty, 1);

      // Fill, reject a fifth word, pop one, then accept it.
      for (int i = 1; i <= 4; i++) cyc(1, 16'(i), 5'b00000, 0, 0, 0);
      chk("fill_full", bus_a.full, 1);
      cyc(1, 16'h0005, 5'b00000, 0, 0, 0);
      chk("fill_hold", bus_a.count, 4);
      chk("fill_head", bus_a.out_z, 16'h0001);
      cyc(1, 16'h0005, 5'b00000, 1, 0, 0);
      chk("fill_after_pop", bus_a.count, 3);
      cyc(1, 16'h0005, 5'b00000, 0, 0, 0);
      for (int i = 2; i <= 5; i++) begin
         chk("drain_order", bus_a.out_z, 16'(i));
         cyc(0, 16'h0, 5'b00000, 1, 0, 0);
      end

      // Streaming through the pointer wrap.
      cyc(1, 16'h0010, 5'b00000, 1, 0, 0);
      for (int i = 1; i < 10; i++) begin
         chk("stream_head", bus_a.out_z, 16'(16'h0010 + i - 1));
         cyc(1, 16'(16'h0010 + i), 5'b00000, 1, 0, 0);
         chk("stream_count", bus_a.count, 1);
      end
      chk("stream_last", bus_a.out_z, 16'h0019);
      cyc(0, 16'h0, 5'b00000, 1, 0, 0);

      // Overflow tracking, clear collision, plain clear, saturation.
      for (int i = 0; i < 3; i++) cyc(1, 16'h8000, 5'b10000, 1, 0, 0);
      chk("ovf_sticky", bus_a.sticky_ovf, 1);
      chk("ovf_cnt3",   bus_a.ovf_cnt,    3);
      cyc(1, 16'h8001, 5'b10000, 1, 1, 0);
      chk("ovf_clr_win",   bus_a.sticky_ovf, 1);
      chk("ovf_clr_cnt",   bus_a.ovf_cnt,    1);
      chk("ovf_clr_cnt_b", bus_b.ovf_cnt,    1);
      cyc(0, 16'h0, 5'b00000, 1, 1, 0);
      chk("ovf_cleared",   bus_a.sticky_ovf, 0);
      chk("ovf_cnt_zero",  bus_a.ovf_cnt,    0);
      for (int i = 0; i < 5; i++) cyc(1, 16'(16'h8100 + i), 5'b10000, 1, 0, 0);
      chk("ovf_sat_b", bus_b.ovf_cnt, 3);
      chk("ovf_cnt5",  bus_a.ovf_cnt, 5);
      cyc(0, 16'h0, 5'b00000, 1, 0, 0);

      // Reset mid-operation.
      for (int i = 0; i < 3; i++) cyc(1, 16'(16'h0100 + i), 5'b10000, 0, 0, 0);
      cyc(1, 16'h1234, 5'b10000, 0, 0, 1);
      chk("rst_count", bus_a.count,     0);
      chk("rst_valid", bus_a.out_valid, 0);
      chk("rst_ovf",   bus_a.ovf_cnt,   0);
      cyc(1, 16'hABCD, 5'b01011, 0, 0, 0);
      chk("rst_next_z",     bus_a.out_z,     16'hABCD);
      chk("rst_next_flags", bus_a.out_flags, 5'b01011);
      cyc(0, 16'h0, 5'b00000, 1, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 9) < 7),
             16'($urandom),
             5'($urandom),
             ($urandom_range(0, 9) < 5),
             ($urandom_range(0, 19) == 0),
             ($urandom_range(0, 49) == 0));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/adder16_result_fifo.md
Name: adder16_result_fifo

Overview:
- Capture stage directly downstream of the 16-bit ripple-carry adder (`adder16bitu4`).
- Registers each adder result (z) and its five status flags into a small FIFO with valid/ready handshake, for consumption by the next datapath stage.
- Maintains a sticky overflow flag and a saturating count of overflowed results, for software/status readback.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result is valid this cycle.
- in_ready  output  1  FIFO can accept a word this cycle.
- z  input  16  adder sum.
- carry  input  1  adder carry-out.
- sign  input  1  adder sign flag.
- parity  input  1  adder parity flag.
- zero  input  1  adder zero flag.
- overflow  input  1  adder signed-overflow flag.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream accepts the head entry.
- out_z  output  16  head sum.
- out_flags  output  5  head flags packed as {overflow, zero, parity, sign, carry}.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- sticky_ovf  output  1  set by any accepted word with overflow=1.
- clr_sticky  input  1  clears sticky_ovf and ovf_cnt.
- ovf_cnt  output  CNT_W  accepted overflow words; saturates at all-ones.

Behaviour:
- Reset: rst sampled high at a rising edge clears:
  - wr_ptr, rd_ptr and count → 0; empty=1, full=0;
  - out_valid=0, out_z=0, out_flags=0;
  - sticky_ovf=0, ovf_cnt=0.
- in_ready is 0 while rst is high and equals !full otherwise.
- Reset mid-operation discards all stored entries. No handshake completes in the reset cycle.
- Push: in_valid && in_ready at an edge writes {overflow, zero, parity, sign, carry, z} (21 bits) at wr_ptr. wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready at an edge advances rd_ptr modulo DEPTH.
- Show-ahead output:
  - out_valid = !empty.
  - out_z/out_flags always show the entry at rd_ptr.
  - out_z/out_flags are 0 when empty.
- Latency: a word pushed at edge N is visible at out_* with out_valid=1 in the cycle after edge N, if the FIFO was empty.
- Occupancy update per edge:
  - push only → count+1;
  - pop only → count-1;
  - push and pop together → count unchanged, both pointers advance.
- Full: in_ready=0; the upstream holds in_valid and data stable. A pop at full frees a slot, and in_ready rises the next cycle (no same-cycle pass-through).
- Empty: out_valid=0; out_ready is ignored.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no gap or duplicate. Entry order is strictly FIFO.
- Overflow tracking, on an accepted push with overflow=1:
  - sticky_ovf ← 1;
  - ovf_cnt ← ovf_cnt+1, holding at 2^CNT_W-1.
- clr_sticky high at an edge: sticky_ovf ← 0, ovf_cnt ← 0. If an accepted overflow push occurs in the same cycle: sticky_ovf=1 and ovf_cnt=1 (the new event wins over the clear).
- Input data is not checked; flags are stored exactly as presented.

Decomposition:
- Package adder16_pkg:
  - DATA_W=16, FLAG_W=5, ENTRY_W=21;
  - flag bit index constants FLG_CARRY=0, FLG_SIGN=1, FLG_PARITY=2, FLG_ZERO=3, FLG_OVF=4;
  - a packed entry type {flags, z}.
- Sub-module adder16_fifo_mem: DEPTH×ENTRY_W register array.
  - One synchronous write port.
  - One asynchronous read port indexed by rd_ptr.
  - No reset on storage; validity comes from count.
- Pointer, occupancy and overflow logic live in the top block.

Test Plan:
- Reset then idle → count=0, empty=1, full=0, in_ready=1, out_valid=0, out_z=0, sticky_ovf=0, ovf_cnt=0.
- Single word: push z=16'hFFFF, carry=0, sign=1, parity=0, zero=0, overflow=0 (the 16'hF0F0 + 16'h0F0F result), out_ready=0 → next cycle out_valid=1, out_z=16'hFFFF, out_flags=5'b00010, count=1; then pulse out_ready → empty=1.
- Fill: push 16'h0001..16'h0004 with out_ready=0 → full=1, in_ready=0. A fifth in_valid holding 16'h0005 is not accepted. Pop one → in_ready=1 the next cycle, 16'h0005 accepted. Drain order is 1,2,3,4,5.
- Streaming with wrap: in_valid=1 and out_ready=1 continuously for 10 words 16'h0010..16'h0019 → count stays at 1 after the first push. Outputs appear in order with one-cycle latency. Pointers pass through 0 twice.
- Overflow: push 3 words with overflow=1 → sticky_ovf=1, ovf_cnt=3. Assert clr_sticky together with a 4th overflow push → sticky_ovf=1, ovf_cnt=1. Clear with no push → both 0. With CNT_W=2, push 5 overflow words → ovf_cnt saturates at 3.
- Reset mid-operation: 3 entries stored, assert rst for one cycle → count=0, out_valid=0, ovf_cnt=0. The next push appears as the head with correct data.
